// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between video scan-out and the CPU port
module vram_arbiter #(
  parameter int A        = 10,
  parameter int D        = 8,
  parameter int WAIT_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vid_req_i,
  input  logic [A-1:0] vid_addr_i,
  output logic         vid_ack_o,
  output logic [D-1:0] vid_rdata_o,
  output logic         vid_rvalid_o,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [A-1:0] cpu_addr_i,
  input  logic [D-1:0] cpu_wdata_i,
  output logic         cpu_ack_o,
  output logic [D-1:0] cpu_rdata_o,
  output logic         cpu_rvalid_o,
  output logic [A-1:0] ram_addr_o,
  output logic [D-1:0] ram_din_o,
  output logic         ram_we_o,
  input  logic [D-1:0] ram_dout_i
);
  localparam logic [3:0] WMAX = 4'(WAIT_MAX);
  logic         cpu_win, vid_win;
  logic [3:0]   wait_q, wait_d;
  logic         vid_ack_q, cpu_ack_q, ram_we_q;
  logic [A-1:0] ram_addr_q;
  logic [D-1:0] ram_din_q;
  logic [1:0]   tag1_q, tag2_q;
  logic         vid_rvalid_q, cpu_rvalid_q;
  logic [D-1:0] vid_rdata_q, cpu_rdata_q;
  // grant: video has priority unless the CPU has already lost WAIT_MAX conflicts in a row
  always_comb begin
    cpu_win = cpu_req_i && (!vid_req_i || wait_q == WMAX);
    vid_win = vid_req_i && !cpu_win;
    wait_d  = (!cpu_req_i || cpu_win) ? 4'd0 : (wait_q == WMAX) ? wait_q : wait_q + 4'd1;
  end
  // starvation counter, acks and registered RAM command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      wait_q    <= wait_d;
      vid_ack_q <= vid_win;
      cpu_ack_q <= cpu_win;
      ram_we_q  <= cpu_win && cpu_we_i;
      if (vid_win) ram_addr_q <= vid_addr_i;
      if (cpu_win) begin
        ram_addr_q <= cpu_addr_i;
        ram_din_q  <= cpu_wdata_i;
      end
    end
  end
  // read tag {valid, port(1=cpu)} follows the access through the RAM latency and steers the return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_q       <= '0;
      tag2_q       <= '0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      tag1_q       <= {vid_win || (cpu_win && !cpu_we_i), cpu_win};
      tag2_q       <= tag1_q;
      vid_rvalid_q <= tag2_q == 2'b10;
      cpu_rvalid_q <= tag2_q == 2'b11;
      if (tag2_q == 2'b10) vid_rdata_q <= ram_dout_i;
      if (tag2_q == 2'b11) cpu_rdata_q <= ram_dout_i;
    end
  end
  assign vid_ack_o    = vid_ack_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_din_o    = ram_din_q;
  assign vid_rvalid_o = vid_rvalid_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign vid_rdata_o  = vid_rdata_q;
  assign cpu_rdata_o  = cpu_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random and directed stimulus against a transaction-level model of the arbiter
module tb_vram_arbiter;
  localparam int A = 10, D = 8, WM = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [A-1:0] vid_addr = '0, cpu_addr = '0;
  logic [D-1:0] cpu_wdata = '0, ram_dout = '0;
  logic vid_ack_o, vid_rvalid_o, cpu_ack_o, cpu_rvalid_o, ram_we_o;
  logic [D-1:0] vid_rdata_o, cpu_rdata_o, ram_din_o;
  logic [A-1:0] ram_addr_o;
  logic [D-1:0] mem [1<<A];
  logic [D-1:0] shadow [1<<A];
  int checks = 0, errors = 0;

  vram_arbiter #(.A(A), .D(D), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(vid_ack_o),
    .vid_rdata_o(vid_rdata_o), .vid_rvalid_o(vid_rvalid_o),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
    ram_dout <= mem[ram_addr_o];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // transaction model: grants from the priority rules, reads return two edges after the grant edge
  typedef struct { int due; bit port; logic [D-1:0] data; } ret_t;
  ret_t rq[$];
  ret_t e;
  int cyc = 0, m_wait = 0;
  bit cw, vw;
  logic m_vack = 0, m_cack = 0, m_we = 0, m_vrv = 0, m_crv = 0;
  logic [A-1:0] m_addr = '0;
  logic [D-1:0] m_din = '0, m_vrd = '0, m_crd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      cyc = 0; m_wait = 0;
      m_vack = 0; m_cack = 0; m_we = 0; m_vrv = 0; m_crv = 0;
      m_addr = '0; m_din = '0; m_vrd = '0; m_crd = '0;
    end else begin
      cyc++;
      m_vrv = 0; m_crv = 0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        if (e.port) begin m_crv = 1; m_crd = e.data; end
        else begin m_vrv = 1; m_vrd = e.data; end
      end
      cw = cpu_req && (!vid_req || m_wait == WM);
      vw = vid_req && !cw;
      m_vack = vw; m_cack = cw; m_we = cw && cpu_we;
      if (vw) begin
        m_addr = vid_addr;
        rq.push_back('{cyc + 2, 1'b0, shadow[vid_addr]});
      end
      if (cw) begin
        m_addr = cpu_addr;
        m_din = cpu_wdata;
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        else rq.push_back('{cyc + 2, 1'b1, shadow[cpu_addr]});
      end
      if (!cpu_req || cw) m_wait = 0;
      else if (m_wait < WM) m_wait++;
    end
  end

  // compare every cycle, away from the rising edge
  always @(negedge clk) begin
    chk("vid_ack", 32'(vid_ack_o), 32'(m_vack));
    chk("cpu_ack", 32'(cpu_ack_o), 32'(m_cack));
    chk("ram_we", 32'(ram_we_o), 32'(m_we));
    chk("ram_addr", 32'(ram_addr_o), 32'(m_addr));
    if (m_we) chk("ram_din", 32'(ram_din_o), 32'(m_din));
    chk("vid_rvalid", 32'(vid_rvalid_o), 32'(m_vrv));
    chk("cpu_rvalid", 32'(cpu_rvalid_o), 32'(m_crv));
    chk("vid_rdata", 32'(vid_rdata_o), 32'(m_vrd));
    chk("cpu_rdata", 32'(cpu_rdata_o), 32'(m_crd));
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  int n_ack, n_rv, cnt;
  logic [9:0] pat;
  logic [4:0] pat5;

  initial begin
    for (int i = 0; i < (1 << A); i++) begin
      mem[i] = D'($urandom);
      shadow[i] = mem[i];
    end
    step;
    chk("reset_ack", 32'(vid_ack_o | cpu_ack_o), 0);
    chk("reset_addr", 32'(ram_addr_o), 0);
    chk("reset_rdata", 32'({vid_rdata_o, cpu_rdata_o}), 0);
    rst_n = 1'b1;
    // random traffic with hold-until-ack requesters
    repeat (400) begin
      step;
      if (!vid_req || vid_ack_o) begin
        vid_req = $urandom_range(0, 2) != 0;
        vid_addr = A'($urandom_range(0, 15));
      end
      if (!cpu_req || cpu_ack_o) begin
        cpu_req = 1'($urandom);
        cpu_we = 1'($urandom);
        cpu_addr = A'($urandom_range(0, 15));
        cpu_wdata = D'($urandom);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) step;
    // CPU write then back-to-back read of the same location
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 'h123; cpu_wdata = 'hA5;
    step;
    chk("wr_ack", 32'(cpu_ack_o), 1);
    chk("wr_we", 32'(ram_we_o), 1);
    chk("wr_din", 32'(ram_din_o), 'hA5);
    cpu_we = 1'b0;
    step;
    chk("rd_ack", 32'(cpu_ack_o), 1);
    chk("rd_we", 32'(ram_we_o), 0);
    cpu_req = 1'b0;
    step;
    chk("rd_rv_early", 32'(cpu_rvalid_o), 0);
    step;
    chk("rd_rv", 32'(cpu_rvalid_o), 1);
    chk("rd_data", 32'(cpu_rdata_o), 'hA5);
    step;
    chk("rd_rv_once", 32'(cpu_rvalid_o), 0);
    // idle: nothing moves
    repeat (10) begin
      step;
      chk("idle_addr", 32'(ram_addr_o), 'h123);
      chk("idle_act", 32'({ram_we_o, vid_ack_o, cpu_ack_o, vid_rvalid_o, cpu_rvalid_o}), 0);
    end
    // video streaming over a preloaded block
    for (int i = 0; i < 8; i++) begin
      mem[i] = D'(i ^ 'h5A);
      shadow[i] = mem[i];
    end
    vid_req = 1'b1; vid_addr = '0; n_ack = 0; n_rv = 0;
    repeat (14) begin
      step;
      if (vid_rvalid_o) begin
        chk("stream_data", 32'(vid_rdata_o), 32'(n_rv ^ 'h5A));
        n_rv++;
      end
      if (vid_ack_o) begin
        n_ack++;
        if (n_ack == 8) vid_req = 1'b0;
        else vid_addr = A'(n_ack);
      end
    end
    chk("stream_acks", 32'(n_ack), 8);
    chk("stream_rvalids", 32'(n_rv), 8);
    // simultaneous single requests: video first, CPU next, data routed separately
    vid_req = 1'b1; vid_addr = 'h3; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 'h2;
    step;
    chk("sim_vid_first", 32'({vid_ack_o, cpu_ack_o}), 'b10);
    vid_req = 1'b0;
    step;
    chk("sim_cpu_next", 32'({vid_ack_o, cpu_ack_o}), 'b01);
    cpu_req = 1'b0;
    step;
    chk("sim_vid_ret", 32'({vid_rvalid_o, cpu_rvalid_o}), 'b10);
    chk("sim_vid_data", 32'(vid_rdata_o), 'h59);
    step;
    chk("sim_cpu_ret", 32'({vid_rvalid_o, cpu_rvalid_o}), 'b01);
    chk("sim_cpu_data", 32'(cpu_rdata_o), 'h58);
    repeat (2) step;
    // sustained conflict: CPU wins every fifth grant
    vid_req = 1'b1; vid_addr = 'h6; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 'h5;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step;
      pat = {pat[8:0], cpu_ack_o};
    end
    chk("conflict_pattern", 32'(pat), 'b0000100001);
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) step;
    // reset while a CPU read is in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 'h7;
    step;
    chk("mid_ack", 32'(cpu_ack_o), 1);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({vid_ack_o, cpu_ack_o, vid_rvalid_o, cpu_rvalid_o, ram_we_o}), 0);
    chk("mid_rst_addr", 32'(ram_addr_o), 0);
    chk("mid_rst_din", 32'(ram_din_o), 0);
    chk("mid_rst_rdata", 32'({vid_rdata_o, cpu_rdata_o}), 0);
    step;
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      step;
      if (vid_rvalid_o || cpu_rvalid_o) cnt++;
    end
    chk("no_rv_after_rst", 32'(cnt), 0);
    // starvation counter restarts from zero after reset
    vid_req = 1'b1; vid_addr = 'h1; cpu_req = 1'b1; cpu_addr = 'h2;
    pat5 = '0;
    for (int i = 0; i < 5; i++) begin
      step;
      pat5 = {pat5[3:0], cpu_ack_o};
    end
    chk("post_rst_wait", 32'(pat5), 'b00001);
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
